// File: rtl/prod_accum_pkg.sv
// Shared definitions for the product accumulator: FSM state encoding and
// default parameter values.
package prod_accum_pkg;

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    localparam int WIDTH_DEF = 8;
    localparam int TERMS_DEF = 4;
    localparam int AW_DEF    = 16;

endpackage

// File: rtl/prod_accum.sv
// Product accumulator: sums TERMS unsigned products per batch (or fewer on
// flush), presents the batch result with a sticky overflow flag, and holds it
// until the downstream consumer takes it.
module prod_accum
    import prod_accum_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int TERMS = TERMS_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] p,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [AW-1:0]    sum,
    output logic [7:0]       terms,
    output logic             ovf
);

    localparam logic [7:0] TERMS_C = 8'(TERMS);

    state_e        state_q, state_d;
    logic [AW-1:0] acc_q, acc_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          ovf_acc_q, ovf_acc_d;
    logic [AW-1:0] sum_q, sum_d;
    logic [7:0]    terms_q, terms_d;
    logic          ovf_q, ovf_d;

    // Datapath helpers: the adder is one bit wider so its carry drives ovf.
    logic          accept_s;
    logic [AW:0]   add_s;
    logic [7:0]    cnt_inc_s;
    logic          ovf_new_s;

    // Handshake flags come straight from the state register.
    assign in_ready  = (state_q == ST_ACC);
    assign out_valid = (state_q == ST_HOLD);
    assign sum       = sum_q;
    assign terms     = terms_q;
    assign ovf       = ovf_q;

    // Next-state and datapath: accumulate, close batches, hand off results.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_acc_d = ovf_acc_q;
        sum_d     = sum_q;
        terms_d   = terms_q;
        ovf_d     = ovf_q;

        accept_s  = in_valid && (state_q == ST_ACC);
        add_s     = {1'b0, acc_q} + {{(AW + 1 - WIDTH){1'b0}}, p};
        cnt_inc_s = cnt_q + 8'd1;
        ovf_new_s = ovf_acc_q | add_s[AW];

        case (state_q)
            ST_ACC: begin
                if (accept_s) begin
                    acc_d     = add_s[AW-1:0];
                    cnt_d     = cnt_inc_s;
                    ovf_acc_d = ovf_new_s;
                    // A product arriving with flush still belongs to this batch.
                    if ((cnt_inc_s == TERMS_C) || flush) begin
                        sum_d   = add_s[AW-1:0];
                        terms_d = cnt_inc_s;
                        ovf_d   = ovf_new_s;
                        state_d = ST_HOLD;
                    end else begin
                        state_d = ST_ACC;
                    end
                end else if (flush && (cnt_q != 8'd0)) begin
                    sum_d   = acc_q;
                    terms_d = cnt_q;
                    ovf_d   = ovf_acc_q;
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_ACC;
                end
            end
            ST_HOLD: begin
                // Result stays frozen until taken; flush and inputs are ignored.
                if (out_ready) begin
                    state_d   = ST_ACC;
                    acc_d     = {AW{1'b0}};
                    cnt_d     = 8'd0;
                    ovf_acc_d = 1'b0;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d   = ST_ACC;
                acc_d     = {AW{1'b0}};
                cnt_d     = 8'd0;
                ovf_acc_d = 1'b0;
            end
        endcase
    end

    // State and result registers; reset wins over every other request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_ACC;
            acc_q     <= {AW{1'b0}};
            cnt_q     <= 8'd0;
            ovf_acc_q <= 1'b0;
            sum_q     <= {AW{1'b0}};
            terms_q   <= 8'd0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ovf_acc_q <= ovf_acc_d;
            sum_q     <= sum_d;
            terms_q   <= terms_d;
            ovf_q     <= ovf_d;
        end
    end

endmodule

// File: tb/tb_prod_accum.sv
// Directed self-checking bench for prod_accum: default configuration plus a
// narrow-accumulator instance for overflow behaviour.
module tb_prod_accum;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, flush, out_ready;
    logic [7:0]  p;
    logic        in_ready, out_valid, ovf;
    logic [15:0] sum;
    logic [7:0]  terms;

    logic        in_valid9, out_ready9, flush9;
    logic [7:0]  p9;
    logic        in_ready9, out_valid9, ovf9;
    logic [8:0]  sum9;
    logic [7:0]  terms9;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    prod_accum #(.WIDTH(8), .TERMS(4), .AW(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .p(p), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .terms(terms), .ovf(ovf)
    );

    prod_accum #(.WIDTH(8), .TERMS(4), .AW(9)) dut9 (
        .clk(clk), .rst(rst), .in_valid(in_valid9), .in_ready(in_ready9),
        .p(p9), .flush(flush9), .out_valid(out_valid9), .out_ready(out_ready9),
        .sum(sum9), .terms(terms9), .ovf(ovf9)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [7:0] v);
        in_valid = 1'b1;
        p        = v;
        step();
        in_valid = 1'b0;
    endtask

    task automatic feed9(input logic [7:0] v);
        in_valid9 = 1'b1;
        p9        = v;
        step();
        in_valid9 = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; p = 8'd0;
        in_valid9 = 1'b0; flush9 = 1'b0; out_ready9 = 1'b0; p9 = 8'd0;
        step();
        step();
        rst = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_terms", terms, 0);
        chk("rst_ovf", ovf, 0);

        // Full batch with a ready consumer.
        out_ready = 1'b1;
        feed(8'd10); feed(8'd20); feed(8'd30);
        chk("full_no_early_valid", out_valid, 0);
        feed(8'd40);
        chk("full_out_valid", out_valid, 1);
        chk("full_in_ready_low", in_ready, 0);
        chk("full_sum", sum, 100);
        chk("full_terms", terms, 4);
        chk("full_ovf", ovf, 0);
        step();
        chk("full_valid_one_cycle", out_valid, 0);
        chk("full_in_ready_back", in_ready, 1);

        // Backpressure: result held, new inputs ignored.
        out_ready = 1'b0;
        feed(8'd1); feed(8'd2); feed(8'd3); feed(8'd4);
        in_valid = 1'b1; p = 8'd99; flush = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("bp_out_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_sum", sum, 10);
            chk("bp_terms", terms, 4);
            step();
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        step();
        chk("bp_release", out_valid, 0);
        out_ready = 1'b0;

        // Flush with an empty batch does nothing.
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_empty_ignored", out_valid, 0);
        chk("flush_empty_in_ready", in_ready, 1);

        // Flush after two products.
        feed(8'd5); feed(8'd7);
        chk("flush_not_yet", out_valid, 0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_out_valid", out_valid, 1);
        chk("flush_sum", sum, 12);
        chk("flush_terms", terms, 2);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Flush coinciding with an accept includes that product.
        feed(8'd5); feed(8'd7);
        flush = 1'b1;
        feed(8'd9);
        flush = 1'b0;
        chk("flush_acc_out_valid", out_valid, 1);
        chk("flush_acc_sum", sum, 21);
        chk("flush_acc_terms", terms, 3);
        out_ready = 1'b1;
        step();

        // Reset mid-batch, with competing requests in the reset cycle.
        feed(8'd50); feed(8'd60);
        rst = 1'b1; in_valid = 1'b1; p = 8'd70; flush = 1'b1;
        step();
        rst = 1'b0; in_valid = 1'b0; flush = 1'b0;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_sum", sum, 0);
        chk("mid_rst_terms", terms, 0);
        chk("mid_rst_ovf", ovf, 0);
        out_ready = 1'b0;
        feed(8'd1); feed(8'd2); feed(8'd3); feed(8'd4);
        chk("post_rst_valid", out_valid, 1);
        chk("post_rst_sum", sum, 10);
        chk("post_rst_terms", terms, 4);
        chk("post_rst_ovf", ovf, 0);
        out_ready = 1'b1;
        step();

        // Overflow on the 9-bit accumulator: 4*255 = 1020 -> 508 with carry.
        out_ready9 = 1'b0;
        feed9(8'd255); feed9(8'd255); feed9(8'd255); feed9(8'd255);
        chk("ovf9_valid", out_valid9, 1);
        chk("ovf9_sum", sum9, 508);
        chk("ovf9_terms", terms9, 4);
        chk("ovf9_flag", ovf9, 1);
        out_ready9 = 1'b1;
        step();
        out_ready9 = 1'b0;
        feed9(8'd1); feed9(8'd1); feed9(8'd1); feed9(8'd1);
        chk("ovf9_next_valid", out_valid9, 1);
        chk("ovf9_next_sum", sum9, 4);
        chk("ovf9_next_flag", ovf9, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/prod_accum.md
PROD_ACCUM -- requirements
Module: prod_accum

Interface
REQ-001 Parameter WIDTH, default 8, product width (matches the upstream multiplier output).
REQ-002 Parameter TERMS, default 4, number of products summed per batch; legal range 2..255.
REQ-003 Parameter AW, default 16, accumulator and sum width; AW >= WIDTH.
REQ-004 clk  input  1  the one clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  p holds a product to accept.
REQ-007 in_ready  output  1  block can accept p this cycle.
REQ-008 p  input  WIDTH  unsigned product from the upstream multiplier.
REQ-009 flush  input  1  close the current batch early.
REQ-010 out_valid  output  1  sum, terms and ovf hold a completed batch.
REQ-011 out_ready  input  1  downstream takes the batch this cycle.
REQ-012 sum  output  AW  batch sum modulo 2^AW.
REQ-013 terms  output  8  number of products in the batch.
REQ-014 ovf  output  1  batch sum exceeded 2^AW-1; sticky within the batch.

Function
REQ-015 The block SHALL implement a two-state FSM: ACC and HOLD.
REQ-016 A product is accepted when in_valid and in_ready are both high on a rising clock edge.
REQ-017 In ACC, in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-018 In HOLD, in_ready SHALL be 0 and out_valid SHALL be 1.
REQ-019 On each accept, the accumulator SHALL become (acc + zero-extended p) mod 2^AW, and the count SHALL increment.
REQ-020 On an accept, ovf SHALL be set if that addition carries out of bit AW-1.
REQ-021 An accept that brings the count to TERMS SHALL register the sum, count and ovf into sum, terms and ovf, and move the FSM to HOLD.
REQ-022 Result latency: out_valid rises the cycle after the closing accept.
REQ-023 In ACC, flush=1 with count>0 SHALL close the batch the same way as REQ-021.
REQ-024 If flush and an accept occur in the same cycle, the accepted product SHALL be included in the closed batch.
REQ-025 flush=1 with count==0 and no accept SHALL be ignored.
REQ-026 flush SHALL be ignored in HOLD.
REQ-027 In HOLD, sum, terms and ovf SHALL remain stable until out_ready=1.
REQ-028 On out_ready=1 in HOLD, the FSM SHALL return to ACC, and the accumulator, count and internal ovf SHALL clear.
REQ-029 The first new product can be accepted in the cycle after the handoff (one bubble cycle per batch).
REQ-030 in_ready and out_valid SHALL be driven from registered state only.
REQ-031 in_ready and out_valid SHALL have no combinational path from in_valid, out_ready or flush.

Reset
REQ-032 rst=1 SHALL force state ACC, in_ready=1, out_valid=0, sum=0, terms=0, ovf=0, accumulator=0 and count=0 at the next edge.
REQ-033 rst SHALL take priority over accept, flush and out_ready in the same cycle.
REQ-034 A partial or held batch SHALL be discarded without being output when rst is asserted.

Structure
REQ-035 A shared package SHALL hold the state encodings (ACC=0, HOLD=1) and the default values of WIDTH, TERMS and AW.
REQ-036 The design SHALL be one flat module with one sequential process and one next-state/combinational process; no sub-module.
REQ-037 The adder SHALL be AW+1 bits wide so that the carry feeds ovf.

Verification (WIDTH=8, TERMS=4, AW=16 unless stated)
REQ-038 Full batch: feed p=10,20,30,40 on consecutive cycles with out_ready=1 -> out_valid for exactly 1 cycle with sum=100, terms=4, ovf=0, one cycle after the 4th accept.
REQ-039 Backpressure: finish a batch with p=1,2,3,4 and hold out_ready=0 for 3 cycles -> sum=10 stable, in_ready=0 for all 3 cycles, and p/in_valid ignored during that time.
REQ-040 Flush: accept p=5,7, then assert flush with in_valid=0 -> sum=12, terms=2.
REQ-041 Flush with a simultaneous accept of p=9 after 5,7 -> sum=21, terms=3.
REQ-042 Overflow, with AW=9: feed p=255 four times -> sum=508, ovf=1. The next batch of 1,1,1,1 -> sum=4, ovf=0.
REQ-043 Reset mid-batch: accept p=50,60, then pulse rst -> all outputs at reset values. A following batch of 1,2,3,4 -> sum=10, terms=4, with no residue from before the reset.
